// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered frame capture with
// E0/F0 prefix decoding into a show-ahead FIFO of {ext, brk, scan code} entries.
module ps2_rx_fifo #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int PARITY_CHECK   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    data_o,
  output logic                          ext_o,
  output logic                          brk_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RX    = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // Index 0 is the PS/2 clock line, index 1 the PS/2 data line.
  logic [1:0]    sync_a, sync_b;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [0:1];
  logic          filt_clk_q;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      filt       <= 2'b11;
      filt_clk_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync_a     <= {ps2_data, ps2_clk};
      sync_b     <= sync_a;
      filt_clk_q <= filt[0];
      // A line only changes after FILTER_LEN consecutive samples disagree with it.
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync_b[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign fall = filt_clk_q & ~filt[0];

  state_t        state, state_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [9:0]    shift, shift_n;
  logic          timeout;

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    timer_n  = timer;
    shift_n  = shift;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall && !filt[1]) begin
          state_n  = S_RX;
          bitcnt_n = 4'd0;
          timer_n  = '0;
        end
      end
      S_RX: begin
        // Shift order is LSB first: shift[7:0]=data, shift[8]=parity, shift[9]=stop.
        if (fall) begin
          shift_n  = {filt[1], shift[9:1]};
          bitcnt_n = bitcnt + 4'd1;
          timer_n  = '0;
          if (bitcnt == 4'd9) state_n = S_CHECK;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = S_IDLE;
          timeout = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_CHECK: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      bitcnt <= 4'd0;
      timer  <= '0;
      shift  <= '0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      timer  <= timer_n;
      shift  <= shift_n;
    end
  end

  assign dbg_state = state;

  logic in_check, stop_ok, par_ok, good, is_e0, is_f0, push_req;
  logic ext_pend, brk_pend;

  assign in_check = (state == S_CHECK);
  assign stop_ok  = shift[9];
  assign par_ok   = (PARITY_CHECK == 0) || (^shift[8:0]);
  assign good     = in_check & stop_ok & par_ok;
  assign is_e0    = (shift[7:0] == 8'hE0);
  assign is_f0    = (shift[7:0] == 8'hF0);
  assign push_req = good & ~is_e0 & ~is_f0;

  // Handshake: an entry transfers on any cycle where valid_o and ready_i are both
  // high; valid_o never depends on ready_i and ready_i is ignored while valid_o is low.
  logic [9:0]    mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [9:0]    push_data;
  logic          full, do_pop, do_push, overflow;

  assign valid_o   = (count != '0);
  assign count_o   = count;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign do_pop    = valid_o & ready_i;
  assign do_push   = push_req & (~full | do_pop);
  assign overflow  = push_req & full & ~do_pop;
  assign push_data = {ext_pend, brk_pend, shift[7:0]};
  assign rd_nxt    = rd_ptr + AW'(do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      {ext_o, brk_o, data_o} <= '0;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + AW'(do_push);
      rd_ptr       <= rd_nxt;
      count        <= count_nxt;
      parity_err_o <= in_check & stop_ok & ~par_ok;
      frame_err_o  <= (in_check & ~stop_ok) | timeout;
      overflow_o   <= overflow;
      // The new head bypasses memory when it is the entry being written this cycle.
      if (count_nxt != '0) begin
        if (do_push && (wr_ptr == rd_nxt)) {ext_o, brk_o, data_o} <= push_data;
        else                               {ext_o, brk_o, data_o} <= mem[rd_nxt];
      end
      if (in_check) begin
        if (good && is_e0) begin
          ext_pend <= 1'b1;
        end else if (good && is_f0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

endmodule
